// File: rtl/forward_hazard_unit_pkg.sv
// Shared pipeline constants: forwarding select encoding and multi-cycle FSM states.
// Combinational definitions only; no timing or flow-control behaviour of its own.
package forward_hazard_unit_pkg;

    localparam int SEL_RF = 0;

    // First post-issue stage whose load result can be forwarded; any younger matching load stalls.
    localparam int LOAD_READY_STAGE = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/forward_hazard_unit_fwd_src_select.sv
// Per-source forwarding select: youngest valid writer of rs wins, zero-cycle combinational.
// Flags a load-use hazard when that youngest writer is a load not yet able to forward.
module fwd_src_select
    import forward_hazard_unit_pkg::*;
#(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int FWD_DEPTH        = 2,
    parameter int SEL_BITWIDTH     = 2
) (
    input  logic [REG_NUM_BITWIDTH-1:0]           rs,
    input  logic [FWD_DEPTH-1:0]                  stage_valid,
    input  logic [FWD_DEPTH-1:0]                  stage_reg_write,
    input  logic [FWD_DEPTH-1:0]                  stage_is_load,
    input  logic [FWD_DEPTH*REG_NUM_BITWIDTH-1:0] stage_rd,
    output logic [SEL_BITWIDTH-1:0]               sel,
    output logic                                  load_use
);

    logic [FWD_DEPTH-1:0] match;

    always_comb begin
        match    = '0;
        sel      = SEL_BITWIDTH'(SEL_RF);
        load_use = 1'b0;
        // rd != 0 already excludes rs == 0, so x0 always reads the register file.
        for (int k = 0; k < FWD_DEPTH; k++) begin
            match[k] = stage_valid[k] && stage_reg_write[k]
                    && (stage_rd[k*REG_NUM_BITWIDTH +: REG_NUM_BITWIDTH] != '0)
                    && (stage_rd[k*REG_NUM_BITWIDTH +: REG_NUM_BITWIDTH] == rs);
        end
        // Scan oldest to youngest so the youngest match is the last one assigned.
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (match[k]) begin
                sel      = SEL_BITWIDTH'(k + 1);
                load_use = stage_is_load[k] && ((k + 1) < LOAD_READY_STAGE);
            end
        end
        if (load_use) begin
            sel = SEL_BITWIDTH'(SEL_RF);
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Issue-stage forwarding/hazard unit: combinational fwd_sel/stall from a FWD_DEPTH shift pipeline.
// Stalls issue on load-use or while a multi-cycle op counts down; flush clears all tracking.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int NUM_SRC          = 2,
    parameter int FWD_DEPTH        = 2,
    parameter int MC_LAT_BITWIDTH  = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     issue_valid,
    input  logic [NUM_SRC*REG_NUM_BITWIDTH-1:0]      issue_rs,
    input  logic [REG_NUM_BITWIDTH-1:0]              issue_rd,
    input  logic                                     issue_regWrite,
    input  logic                                     issue_isLoad,
    input  logic [MC_LAT_BITWIDTH-1:0]               issue_mcLat,
    input  logic                                     flush,
    output logic [NUM_SRC*$clog2(FWD_DEPTH+1)-1:0]   fwd_sel,
    output logic                                     stall,
    output logic                                     busy
);

    localparam int SEL_BITWIDTH = $clog2(FWD_DEPTH + 1);
    localparam int W            = REG_NUM_BITWIDTH;

    logic [FWD_DEPTH-1:0]   stage_valid;
    logic [FWD_DEPTH-1:0]   stage_reg_write;
    logic [FWD_DEPTH-1:0]   stage_is_load;
    logic [FWD_DEPTH*W-1:0] stage_rd;
    logic [NUM_SRC-1:0]     src_load_use;

    mc_state_t                  state, state_nxt;
    logic [MC_LAT_BITWIDTH-1:0] mc_cnt, mc_cnt_nxt;

    logic accept;
    logic load_use_stall;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            fwd_src_select #(
                .REG_NUM_BITWIDTH (REG_NUM_BITWIDTH),
                .FWD_DEPTH        (FWD_DEPTH),
                .SEL_BITWIDTH     (SEL_BITWIDTH)
            ) u_fwd_src_select (
                .rs              (issue_rs[i*W +: W]),
                .stage_valid     (stage_valid),
                .stage_reg_write (stage_reg_write),
                .stage_is_load   (stage_is_load),
                .stage_rd        (stage_rd),
                .sel             (fwd_sel[i*SEL_BITWIDTH +: SEL_BITWIDTH]),
                .load_use        (src_load_use[i])
            );
        end
    endgenerate

    assign load_use_stall = |src_load_use;
    assign busy           = (state == BUSY);
    assign stall          = load_use_stall | busy;
    assign accept         = issue_valid & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid     <= '0;
            stage_reg_write <= '0;
            stage_is_load   <= '0;
            stage_rd        <= '0;
        end else if (flush) begin
            stage_valid <= '0;
        end else begin
            for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
                stage_valid[k]         <= stage_valid[k-1];
                stage_reg_write[k]     <= stage_reg_write[k-1];
                stage_is_load[k]       <= stage_is_load[k-1];
                stage_rd[k*W +: W]     <= stage_rd[(k-1)*W +: W];
            end
            // A stalled or absent issue enters stage 1 as a bubble.
            stage_valid[0]     <= accept;
            stage_reg_write[0] <= issue_regWrite;
            stage_is_load[0]   <= issue_isLoad;
            stage_rd[0 +: W]   <= issue_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mc_cnt_nxt = mc_cnt;
        if (flush) begin
            state_nxt  = IDLE;
            mc_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && (issue_mcLat != '0)) begin
                        state_nxt  = BUSY;
                        mc_cnt_nxt = issue_mcLat;
                    end
                end
                BUSY: begin
                    // Count L..1 while busy so exactly L cycles are spent here.
                    if (mc_cnt <= MC_LAT_BITWIDTH'(1)) begin
                        state_nxt  = IDLE;
                        mc_cnt_nxt = '0;
                    end else begin
                        mc_cnt_nxt = mc_cnt - MC_LAT_BITWIDTH'(1);
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    mc_cnt_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Randomized and directed bench for forward_hazard_unit against a list-of-in-flight-instructions model.
module tb_forward_hazard_unit;

    localparam int W  = 5;
    localparam int NS = 2;
    localparam int D  = 2;
    localparam int MW = 4;
    localparam int SW = $clog2(D + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              issue_valid;
    logic [NS*W-1:0]   issue_rs;
    logic [W-1:0]      issue_rd;
    logic              issue_regWrite;
    logic              issue_isLoad;
    logic [MW-1:0]     issue_mcLat;
    logic              flush;
    logic [NS*SW-1:0]  fwd_sel;
    logic              stall;
    logic              busy;

    always #5 clk = ~clk;

    forward_hazard_unit #(
        .REG_NUM_BITWIDTH (W),
        .NUM_SRC          (NS),
        .FWD_DEPTH        (D),
        .MC_LAT_BITWIDTH  (MW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .issue_rs       (issue_rs),
        .issue_rd       (issue_rd),
        .issue_regWrite (issue_regWrite),
        .issue_isLoad   (issue_isLoad),
        .issue_mcLat    (issue_mcLat),
        .flush          (flush),
        .fwd_sel        (fwd_sel),
        .stall          (stall),
        .busy           (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: what each post-issue stage holds, and how many busy cycles remain.
    bit       m_valid [1:D];
    int       m_rd    [1:D];
    bit       m_wr    [1:D];
    bit       m_ld    [1:D];
    int       m_left;

    int exp_sel [NS];
    bit exp_stall, exp_busy, exp_accept;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int dut_sel(input int i);
        return int'(fwd_sel[i*SW +: SW]);
    endfunction

    function automatic void model_reset();
        for (int k = 1; k <= D; k++) begin
            m_valid[k] = 0; m_rd[k] = 0; m_wr[k] = 0; m_ld[k] = 0;
        end
        m_left = 0;
    endfunction

    function automatic void model_eval();
        exp_busy  = (m_left > 0);
        exp_stall = exp_busy;
        for (int i = 0; i < NS; i++) begin
            int  rs;
            bit  found;
            rs         = int'(issue_rs[i*W +: W]);
            exp_sel[i] = 0;
            found      = 0;
            if (rs != 0) begin
                for (int k = 1; k <= D; k++) begin
                    if (!found && m_valid[k] && m_wr[k] && m_rd[k] != 0 && m_rd[k] == rs) begin
                        found = 1;
                        if (k == 1 && m_ld[k]) exp_stall = 1;
                        else exp_sel[i] = k;
                    end
                end
            end
        end
        exp_accept = issue_valid && !exp_stall;
    endfunction

    task automatic drive(input bit v, input int rs0, input int rs1, input int rd,
                         input bit wr, input bit ld, input int mc, input bit fl);
        issue_valid    = v;
        issue_rs       = {W'(rs1), W'(rs0)};
        issue_rd       = W'(rd);
        issue_regWrite = wr;
        issue_isLoad   = ld;
        issue_mcLat    = MW'(mc);
        flush          = fl;
    endtask

    task automatic settle(input string tag);
        #1;
        model_eval();
        for (int i = 0; i < NS; i++)
            check($sformatf("%s_sel%0d", tag, i), dut_sel(i), exp_sel[i]);
        check({tag, "_stall"}, int'(stall), int'(exp_stall));
        check({tag, "_busy"},  int'(busy),  int'(exp_busy));
    endtask

    task automatic adv();
        model_eval();
        @(posedge clk);
        if (flush) begin
            for (int k = 1; k <= D; k++) m_valid[k] = 0;
            m_left = 0;
        end else begin
            for (int k = D; k >= 2; k--) begin
                m_valid[k] = m_valid[k-1]; m_rd[k] = m_rd[k-1];
                m_wr[k]    = m_wr[k-1];    m_ld[k] = m_ld[k-1];
            end
            m_valid[1] = exp_accept;
            m_rd[1]    = int'(issue_rd);
            m_wr[1]    = issue_regWrite;
            m_ld[1]    = issue_isLoad;
            if (m_left > 0) m_left--;
            else if (exp_accept && issue_mcLat != 0) m_left = int'(issue_mcLat);
        end
        @(negedge clk);
    endtask

    task automatic step(input string tag, input bit v, input int rs0, input int rs1, input int rd,
                        input bit wr, input bit ld, input int mc, input bit fl);
        drive(v, rs0, rs1, rd, wr, ld, mc, fl);
        settle(tag);
        adv();
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #2;
        check("rst_sel0", dut_sel(0), 0);
        check("rst_sel1", dut_sel(1), 0);
        check("rst_stall", int'(stall), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 3, 4, 3, 1, 1, 0, 0);
        settle("post_rst");
        check("post_rst_sel0_zero", dut_sel(0), 0);
        check("post_rst_stall_zero", int'(stall), 0);
        adv();

        // Stage-1 priority over stage-2 for the same register.
        step("p_a", 1, 0, 0, 5, 1, 0, 0, 0);
        step("p_b", 1, 0, 0, 5, 1, 0, 0, 0);
        drive(1, 5, 0, 0, 0, 0, 0, 0);
        settle("prio");
        check("prio_sel0", dut_sel(0), 1);
        check("prio_stall", int'(stall), 0);
        adv();

        // Each source looks only at its own register number.
        step("i_flush", 0, 0, 0, 0, 0, 0, 0, 1);
        step("i_a", 1, 0, 0, 7, 1, 0, 0, 0);
        step("i_b", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 3, 7, 0, 0, 0, 0, 0);
        settle("indep");
        check("indep_sel0", dut_sel(0), 0);
        check("indep_sel1", dut_sel(1), 2);
        adv();

        // x0 never forwards.
        step("z_a", 1, 0, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        settle("x0");
        check("x0_sel0", dut_sel(0), 0);
        check("x0_stall", int'(stall), 0);
        adv();

        // Load-use: one stall cycle, then forward from stage 2 and accept.
        step("l_a", 1, 0, 0, 9, 1, 1, 0, 0);
        drive(1, 0, 9, 12, 1, 0, 0, 0);
        settle("lu1");
        check("lu1_stall", int'(stall), 1);
        check("lu1_sel1", dut_sel(1), 0);
        adv();
        drive(1, 0, 9, 12, 1, 0, 0, 0);
        settle("lu2");
        check("lu2_stall", int'(stall), 0);
        check("lu2_sel1", dut_sel(1), 2);
        adv();
        drive(1, 12, 0, 0, 0, 0, 0, 0);
        settle("lu3");
        check("lu3_accepted_sel0", dut_sel(0), 1);
        adv();

        // Multi-cycle: exactly three busy cycles.
        step("m_a", 1, 0, 0, 0, 0, 0, 3, 0);
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0);
            settle($sformatf("mc%0d", c));
            check($sformatf("mc%0d_busy_hi", c), int'(busy), 1);
            check($sformatf("mc%0d_stall_hi", c), int'(stall), 1);
            adv();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle("mc_end");
        check("mc_end_busy_lo", int'(busy), 0);
        adv();

        // Flush in the second busy cycle ends the operation.
        step("f_a", 1, 0, 0, 0, 0, 0, 3, 0);
        step("f_b", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        settle("f_c");
        check("f_c_busy_hi", int'(busy), 1);
        adv();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle("f_d");
        check("flush_busy_lo", int'(busy), 0);
        adv();

        // Reset during BUSY with two cycles left.
        step("r_a", 1, 0, 0, 6, 1, 0, 3, 0);
        step("r_b", 0, 0, 0, 0, 0, 0, 0, 0);
        check("r_model_left", m_left, 2);
        rst_n = 1'b0;
        #1;
        check("rmid_stall", int'(stall), 0);
        check("rmid_busy", int'(busy), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 6, 6, 0, 0, 0, 0, 0);
        settle("rmid_rel");
        check("rmid_sel0", dut_sel(0), 0);
        check("rmid_sel1", dut_sel(1), 0);
        adv();

        // Random traffic over a small register range to force frequent matches.
        for (int n = 0; n < 400; n++) begin
            step("rnd",
                 $urandom_range(0, 9) < 8,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0,
                 $urandom_range(0, 29) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL have parameter REG_NUM_BITWIDTH, default 5, register-number width.
REQ-002 SHALL have parameter NUM_SRC, default 2, number of source operands checked per issue (1..4).
REQ-003 SHALL have parameter FWD_DEPTH, default 2, number of post-issue stages able to forward (1..4); stage 1 = EX, 2 = MEM, and so on.
REQ-004 SHALL have parameter MC_LAT_BITWIDTH, default 4, width of the multi-cycle latency field.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port issue_valid, input, 1, instruction present at issue.
REQ-008 SHALL have port issue_rs, input, NUM_SRC*REG_NUM_BITWIDTH, packed sources; source i occupies bits [i*W +: W].
REQ-009 SHALL have port issue_rd, input, REG_NUM_BITWIDTH, destination register.
REQ-010 SHALL have port issue_regWrite, input, 1, instruction writes issue_rd.
REQ-011 SHALL have port issue_isLoad, input, 1, result available only at stage 2.
REQ-012 SHALL have port issue_mcLat, input, MC_LAT_BITWIDTH, extra busy cycles; 0 = single-cycle.
REQ-013 SHALL have port flush, input, 1, kill all in-flight tracking.
REQ-014 SHALL have port fwd_sel, output, NUM_SRC*clog2(FWD_DEPTH+1), per-source select; 0 = register file, k = stage k.
REQ-015 SHALL have port stall, output, 1, issue blocked this cycle.
REQ-016 SHALL have port busy, output, 1, multi-cycle operation in progress.

Function
REQ-017 SHALL keep a FWD_DEPTH-entry shift pipeline of {valid, rd, regWrite, isLoad}, advanced every clock edge.
REQ-018 SHALL treat an issue as accepted when issue_valid=1 and stall=0; the accepted entry enters stage 1 on that edge, otherwise a bubble (valid=0) enters.
REQ-019 SHALL count a stage k as a match for source i only when it is valid, has regWrite=1, has rd!=0, and has rd equal to rs_i.
REQ-020 SHALL compute fwd_sel for source i combinationally: 0 if rs_i==0, else the lowest-numbered (youngest) matching stage, else 0; every source is compared against its own rs_i only.
REQ-021 SHALL assert a load-use stall when the stage-1 entry is a matching load (isLoad=1) for any source i; fwd_sel for that source is then 0.
REQ-022 SHALL contain a two-state FSM, IDLE/BUSY, with down-counter mc_cnt.
REQ-023 SHALL, on acceptance of an instruction with issue_mcLat=L>0 in IDLE, load mc_cnt=L and move to BUSY.
REQ-024 SHALL, in BUSY, decrement mc_cnt each edge and return to IDLE when it reaches 0; stall and busy are thus asserted for exactly L cycles after the accept cycle.
REQ-025 SHALL compute stall = load-use stall OR busy.
REQ-026 SHALL keep forwarding decisions valid during stall for entries still in the pipeline.
REQ-027 SHALL, when flush=1 at an edge, invalidate all entries, clear mc_cnt, and enter IDLE; flush overrides a simultaneous accept, and no entry is pushed.
REQ-028 SHALL treat issue_mcLat as ignored when issue_valid=0 or stall=1.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously clear all pipeline valid bits, clear mc_cnt, and force state IDLE.
REQ-030 SHALL drive fwd_sel=0, stall=0, and busy=0 in reset, and in the first cycle after reset.
REQ-031 SHALL abandon any multi-cycle operation or load-use stall in progress when reset is asserted mid-operation, with no residual stall.

Structure
REQ-032 SHALL place the fwd_sel encoding constants (SEL_RF=0) and the IDLE/BUSY state encoding in the shared pipeline package.
REQ-033 SHALL implement per-source select logic as one sub-module, fwd_src_select, instantiated NUM_SRC times via generate.

Verification
REQ-034 SHALL cover stage-1 priority: x5 written at stage 1 and x5 at stage 2, rs1=5 -> sel[0]=1, stall=0.
REQ-035 SHALL cover per-source independence: stage-2 rd=7, rs1=3, rs2=7 -> sel[0]=0, sel[1]=2.
REQ-036 SHALL cover x0 handling: stage-1 rd=0 with regWrite=1, rs1=0 -> sel[0]=0, no stall.
REQ-037 SHALL cover load-use: a load to x9 accepted, next rs2=9 -> stall=1 for 1 cycle; then sel[1]=2 and the instruction is accepted.
REQ-038 SHALL cover multi-cycle: accept with mcLat=3 -> busy/stall high exactly 3 cycles; a flush in the 2nd cycle -> busy=0 next cycle.
REQ-039 SHALL cover reset mid-operation: rst_n low during BUSY with mc_cnt=2 -> stall=0 immediately, all sel=0 after release.
